memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_if.sv | 14 +
 rtl/memory.sv | 30 +++
 tb/tb_memory.sv | 137 +++++++++++++
 3 files changed

// File: rtl/memory_if.sv
// Bus bundle for the single-port word memory: command/address/data in, registered read data out.
interface memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  memwr;
    logic                  memrd;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] datao;

    modport master (output memwr, memrd, data, address, input datao);
    modport slave  (input memwr, memrd, data, address, output datao);
endinterface

// File: rtl/memory.sv
// Single-port word memory, one-cycle registered read, write-first on simultaneous read/write.
// All words and the read register clear asynchronously while res is low.
module memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic     clk,
    input  logic     res,
    memory_if.slave  bus
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_datao;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Write-first: a same-edge write forwards its data straight to the output.
    assign w_rd_word = bus.memwr ? bus.data : r_mem[bus.address];
    assign bus.datao = r_datao;

    // Storage uses flops rather than a RAM macro so every word can clear on reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_datao <= '0;
        end else begin
            if (bus.memwr) r_mem[bus.address] <= bus.data;
            if (bus.memrd) r_datao <= w_rd_word;
        end
    end
endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus queues expected datao, a monitor pops and compares.
module tb_memory;
    localparam int DW = 32;
    localparam int AW = 6;

    typedef struct {
        logic [DW-1:0] exp;
        string         name;
    } ent_t;

    logic   clk;
    logic   res;
    ent_t   q[$];
    int     checks   = 0;
    int     failures = 0;

    memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares every pending expectation one step after a falling clock or reset edge.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk or negedge res);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.datao !== e.exp) begin
                    failures++;
                    $display("FAIL %s: datao=%h expected=%h", e.name, bus.datao, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input logic [DW-1:0] exp, input string name);
        ent_t e;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    // One clock of stimulus; when chk is set, datao after this edge must equal exp.
    task automatic cyc(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic chk,
                       input logic [DW-1:0] exp, input string name);
        bus.memwr   = wr;
        bus.memrd   = rd;
        bus.address = a;
        bus.data    = d;
        @(posedge clk);
        if (chk) expect_val(exp, name);
        #1;
    endtask

    initial begin
        res         = 1'b0;
        bus.memwr   = 1'b0;
        bus.memrd   = 1'b0;
        bus.address = '0;
        bus.data    = '0;
        #2;
        expect_val(32'h0, "reset_datao");
        // Commands during reset are ignored; address 0 is read back as 0 afterwards.
        cyc(1'b1, 1'b1, 6'd0, 32'hFFFF_FFFF, 1'b1, 32'h0, "reset_ignores_cmd");
        res = 1'b1;

        cyc(1'b0, 1'b1, 6'd0,  32'h0, 1'b1, 32'h0, "post_reset_rd0");
        cyc(1'b0, 1'b1, 6'd34, 32'h0, 1'b1, 32'h0, "post_reset_rd34");
        cyc(1'b0, 1'b1, 6'd63, 32'h0, 1'b1, 32'h0, "post_reset_rd63");

        cyc(1'b1, 1'b0, 6'd34, 32'h1, 1'b0, 32'h0, "");
        cyc(1'b0, 1'b1, 6'd34, 32'h0, 1'b1, 32'h0000_0001, "rd34_after_wr");

        cyc(1'b1, 1'b0, 6'd5, 32'd9, 1'b0, 32'h0, "");
        cyc(1'b0, 1'b1, 6'd4, 32'h0, 1'b1, 32'h0, "rd4_neighbor");
        cyc(1'b0, 1'b1, 6'd5, 32'h0, 1'b1, 32'd9, "rd5_after_wr");

        cyc(1'b1, 1'b1, 6'd10, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "write_first");

        cyc(1'b0, 1'b1, 6'd5,  32'h0,         1'b1, 32'd9, "rd5_again");
        cyc(1'b0, 1'b0, 6'd10, 32'h1234_5678, 1'b1, 32'd9, "hold_1");
        cyc(1'b0, 1'b0, 6'd34, 32'hCAFE_F00D, 1'b1, 32'd9, "hold_2");
        cyc(1'b0, 1'b1, 6'd10, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd10_no_wr");

        // Addresses differing only in upper bits must not alias.
        cyc(1'b1, 1'b0, 6'd0,  32'h11, 1'b0, 32'h0, "");
        cyc(1'b1, 1'b0, 6'd32, 32'h22, 1'b0, 32'h0, "");
        cyc(1'b1, 1'b0, 6'd31, 32'h33, 1'b0, 32'h0, "");
        cyc(1'b0, 1'b1, 6'd0,  32'h0, 1'b1, 32'h11, "alias_rd0");
        cyc(1'b0, 1'b1, 6'd32, 32'h0, 1'b1, 32'h22, "alias_rd32");
        cyc(1'b0, 1'b1, 6'd31, 32'h0, 1'b1, 32'h33, "alias_rd31");
        cyc(1'b0, 1'b1, 6'd63, 32'h0, 1'b1, 32'h0,  "alias_rd63");
        cyc(1'b0, 1'b1, 6'd34, 32'h0, 1'b1, 32'h1,  "alias_rd34");

        cyc(1'b1, 1'b0, 6'd63, 32'hFFFF_FFFF, 1'b0, 32'h0, "");
        cyc(1'b0, 1'b1, 6'd63, 32'h0, 1'b1, 32'hFFFF_FFFF, "rd63_ones");

        // Reset pulse between edges: datao must clear with no clock edge.
        bus.memwr = 1'b0;
        bus.memrd = 1'b0;
        @(negedge clk);
        #2;
        expect_val(32'h0, "async_reset_datao");
        res = 1'b0;
        #2;
        res = 1'b1;

        cyc(1'b0, 1'b1, 6'd63, 32'h0, 1'b1, 32'h0, "rd63_after_reset");
        cyc(1'b0, 1'b1, 6'd34, 32'h0, 1'b1, 32'h0, "rd34_after_reset");
        cyc(1'b0, 1'b1, 6'd10, 32'h0, 1'b1, 32'h0, "rd10_after_reset");
        cyc(1'b0, 1'b1, 6'd5,  32'h0, 1'b1, 32'h0, "rd5_after_reset");
        cyc(1'b1, 1'b0, 6'd7,  32'h55, 1'b0, 32'h0, "");
        cyc(1'b0, 1'b1, 6'd7,  32'h0, 1'b1, 32'h55, "rd7_resumed");
        cyc(1'b0, 1'b0, 6'd0,  32'h0, 1'b0, 32'h0, "");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
